// File: rtl/vector_control_seq.sv
// Sequenced vector opcode decoder: accepts one opcode + vector length, then
// issues the registered datapath controls as a stream of lane-group beats.
module vector_control_seq #(
    parameter int NUM_LANES  = 4,
    parameter int VLEN_W     = 8,
    parameter int DIV_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [VLEN_W-1:0]    vlen,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 regWrite,
    output logic                 aluSrc,
    output logic                 PCSrc,
    output logic                 immSrc,
    output logic                 flagUpdate,
    output logic                 memToReg,
    output logic                 memWrite,
    output logic                 ra2Src,
    output logic                 ra1Src,
    output logic                 aluSrc1,
    output logic                 aluSrc2,
    output logic                 zeroToAlu,
    output logic [2:0]           aluControl,
    output logic [VLEN_W-1:0]    elem_idx,
    output logic [NUM_LANES-1:0] lane_mask,
    output logic                 last,
    output logic                 illegal
);

    localparam int LANE_SHIFT = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
    localparam int WAIT_W     = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (DIV_CYCLES > 2) ? WAIT_W'(DIV_CYCLES - 2) : '0;
    localparam logic [VLEN_W-1:0] LANE_STEP = VLEN_W'(NUM_LANES);
    localparam bit DIV_STALLS = (DIV_CYCLES > 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_t;

    typedef enum logic [3:0] {
        OP_MUL    = 4'b0000,
        OP_DIV    = 4'b0001,
        OP_LOAD   = 4'b0010,
        OP_STORE  = 4'b0011,
        OP_ADD    = 4'b0100,
        OP_SUB    = 4'b0101,
        OP_ADDI   = 4'b0110,
        OP_SUBI   = 4'b0111,
        OP_BRANCH = 4'b1000,
        OP_BEQ    = 4'b1001
    } opcode_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       pc_src;
        logic       imm_src;
        logic       flag_update;
        logic       mem_to_reg;
        logic       mem_write;
        logic       ra2_src;
        logic       ra1_src;
        logic       alu_src1;
        logic       alu_src2;
        logic       zero_to_alu;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    state_t              state;
    state_t              state_d;
    ctrl_t               dec;
    ctrl_t               ctrl_q;
    logic                single_beat_d;
    logic                accept;
    logic                advance;
    logic                load_wait;
    logic                is_div_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [VLEN_W-1:0]   vlen_q;
    logic [VLEN_W-1:0]   beats_left;
    logic [VLEN_W-1:0]   vlen_eff;
    logic [VLEN_W-1:0]   first_left;
    logic [NUM_LANES-1:0] first_mask;
    logic [VLEN_W-1:0]   elem_next;
    logic                final_next;
    logic [NUM_LANES-1:0] mask_next;

    // Lanes 0..count-1 active; count is always in 1..NUM_LANES where used.
    function automatic logic [NUM_LANES-1:0] lane_fill(input logic [VLEN_W-1:0] count);
        logic [NUM_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            m[i] = (i < 32'(count));
        end
        return m;
    endfunction

    always_comb begin
        dec           = '0;
        single_beat_d = 1'b0;
        case (opcode)
            OP_MUL: begin
                dec.alu_control = 3'b001;
                dec.reg_write   = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
            end
            OP_DIV: begin
                dec.alu_control = 3'b010;
                dec.reg_write   = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.flag_update = 1'b1;
                dec.imm_src     = 1'b1;
                dec.alu_src1    = 1'b1;
                dec.zero_to_alu = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src     = 1'b1;
                dec.imm_src     = 1'b1;
                dec.mem_write   = 1'b1;
                dec.ra2_src     = 1'b1;
                dec.alu_src1    = 1'b1;
                dec.zero_to_alu = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                dec.alu_control = (opcode == OP_SUB) ? 3'b100 : 3'b000;
                dec.reg_write   = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                dec.alu_control = (opcode == OP_SUBI) ? 3'b100 : 3'b000;
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.alu_src1    = 1'b1;
                dec.zero_to_alu = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_src     = 1'b1;
                dec.pc_src      = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.ra2_src     = 1'b1;
                dec.ra1_src     = 1'b1;
                dec.alu_src1    = 1'b1;
                dec.zero_to_alu = 1'b1;
                single_beat_d   = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_control = 3'b011;
                dec.pc_src      = 1'b1;
                dec.flag_update = 1'b1;
                dec.mem_to_reg  = 1'b1;
                single_beat_d   = 1'b1;
            end
            default: begin
                dec.mem_to_reg  = 1'b1;
                dec.illegal     = 1'b1;
                single_beat_d   = 1'b1;
            end
        endcase
    end

    // beats_left holds (beats remaining - 1), so it never exceeds vlen-1 and
    // fits in VLEN_W bits even for the largest vector length.
    always_comb begin
        vlen_eff   = (vlen == '0) ? VLEN_W'(1) : vlen;
        first_left = single_beat_d ? '0 : ((vlen_eff - VLEN_W'(1)) >> LANE_SHIFT);
        if (first_left != '0) begin
            first_mask = '1;
        end else if (single_beat_d) begin
            first_mask = lane_fill(VLEN_W'(1));
        end else begin
            first_mask = lane_fill(vlen_eff);
        end
    end

    always_comb begin
        elem_next  = elem_idx + LANE_STEP;
        final_next = (beats_left == VLEN_W'(1));
        mask_next  = final_next ? lane_fill(vlen_q - elem_next) : '1;
    end

    assign in_ready = (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        out_valid = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        load_wait = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (opcode == OP_DIV && DIV_STALLS) begin
                        state_d   = WAIT;
                        load_wait = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        if (is_div_q && DIV_STALLS) begin
                            state_d   = WAIT;
                            load_wait = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            vlen_q     <= '0;
            elem_idx   <= '0;
            beats_left <= '0;
            lane_mask  <= '0;
            last       <= 1'b0;
            is_div_q   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                ctrl_q     <= dec;
                vlen_q     <= vlen_eff;
                elem_idx   <= '0;
                beats_left <= first_left;
                lane_mask  <= first_mask;
                last       <= (first_left == '0);
                is_div_q   <= (opcode == OP_DIV);
            end else if (advance) begin
                elem_idx   <= elem_next;
                beats_left <= beats_left - VLEN_W'(1);
                lane_mask  <= mask_next;
                last       <= final_next;
            end
            if (load_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

    assign regWrite   = ctrl_q.reg_write;
    assign aluSrc     = ctrl_q.alu_src;
    assign PCSrc      = ctrl_q.pc_src;
    assign immSrc     = ctrl_q.imm_src;
    assign flagUpdate = ctrl_q.flag_update;
    assign memToReg   = ctrl_q.mem_to_reg;
    assign memWrite   = ctrl_q.mem_write;
    assign ra2Src     = ctrl_q.ra2_src;
    assign ra1Src     = ctrl_q.ra1_src;
    assign aluSrc1    = ctrl_q.alu_src1;
    assign aluSrc2    = ctrl_q.alu_src2;
    assign zeroToAlu  = ctrl_q.zero_to_alu;
    assign aluControl = ctrl_q.alu_control;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_vector_control_seq.sv
// Bench for vector_control_seq: directed scenarios plus randomized instructions
// checked against a table-driven beat model.
module tb_vector_control_seq;

    localparam int NL = 4;
    localparam int VW = 8;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    opcode = '0;
    logic [VW-1:0] vlen = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic regWrite, aluSrc, PCSrc, immSrc, flagUpdate, memToReg;
    logic memWrite, ra2Src, ra1Src, aluSrc1, aluSrc2, zeroToAlu;
    logic [2:0]    aluControl;
    logic [VW-1:0] elem_idx;
    logic [NL-1:0] lane_mask;
    logic          last;
    logic          illegal;

    int n_checks = 0;
    int n_fail = 0;

    vector_control_seq #(.NUM_LANES(NL), .VLEN_W(VW), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .vlen(vlen), .out_valid(out_valid), .out_ready(out_ready),
        .regWrite(regWrite), .aluSrc(aluSrc), .PCSrc(PCSrc), .immSrc(immSrc),
        .flagUpdate(flagUpdate), .memToReg(memToReg), .memWrite(memWrite),
        .ra2Src(ra2Src), .ra1Src(ra1Src), .aluSrc1(aluSrc1), .aluSrc2(aluSrc2),
        .zeroToAlu(zeroToAlu), .aluControl(aluControl), .elem_idx(elem_idx),
        .lane_mask(lane_mask), .last(last), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] obs_ctrl;
    assign obs_ctrl = {regWrite, aluSrc, PCSrc, immSrc, flagUpdate, memToReg, memWrite,
                       ra2Src, ra1Src, aluSrc1, aluSrc2, zeroToAlu, aluControl, illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control word straight from the opcode table, same packing as obs_ctrl.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] op);
        logic rw, as, pc, im, fu, mr, mw, r2, r1, a1, a2, z, il;
        logic [2:0] ac;
        {rw, as, pc, im, fu, mr, mw, r2, r1, a1, a2, z, il} = '0;
        ac = 3'b000;
        case (op)
            4'd0: begin ac = 3'b001; rw = 1; fu = 1; mr = 1; end
            4'd1: begin ac = 3'b010; rw = 1; fu = 1; mr = 1; end
            4'd2: begin rw = 1; as = 1; fu = 1; im = 1; a1 = 1; z = 1; end
            4'd3: begin as = 1; im = 1; mw = 1; r2 = 1; a1 = 1; z = 1; end
            4'd4: begin rw = 1; fu = 1; mr = 1; end
            4'd5: begin rw = 1; fu = 1; mr = 1; ac = 3'b100; end
            4'd6: begin rw = 1; as = 1; fu = 1; mr = 1; a1 = 1; z = 1; end
            4'd7: begin rw = 1; as = 1; fu = 1; mr = 1; a1 = 1; z = 1; ac = 3'b100; end
            4'd8: begin as = 1; pc = 1; fu = 1; mr = 1; r2 = 1; r1 = 1; a1 = 1; z = 1; end
            4'd9: begin ac = 3'b011; pc = 1; fu = 1; mr = 1; end
            default: begin mr = 1; il = 1; end
        endcase
        return {rw, as, pc, im, fu, mr, mw, r2, r1, a1, a2, z, ac, il};
    endfunction

    function automatic int exp_beats(input logic [3:0] op, input logic [VW-1:0] vl);
        int veff;
        if (op >= 4'd8) return 1;
        veff = (vl == 0) ? 1 : int'(vl);
        return (veff + NL - 1) / NL;
    endfunction

    function automatic logic [NL-1:0] exp_mask(input logic [3:0] op, input logic [VW-1:0] vl,
                                               input int b);
        int veff;
        int rem;
        if (op >= 4'd8) return NL'(1);
        veff = (vl == 0) ? 1 : int'(vl);
        if (b == exp_beats(op, vl) - 1) begin
            rem = veff - b * NL;
            return NL'((1 << rem) - 1);
        end
        return NL'((1 << NL) - 1);
    endfunction

    function automatic int exp_gap(input logic [3:0] op);
        return (op == 4'd1 && DC > 1) ? DC - 1 : 0;
    endfunction

    task automatic offer(input logic [3:0] op, input logic [VW-1:0] vl);
        in_valid = 1'b1;
        opcode = op;
        vlen = vl;
        tick();
        in_valid = 1'b0;
        opcode = 4'($urandom);
        vlen = VW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        opcode = 4'd4;
        vlen = 8'd8;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({out_valid, last, lane_mask, elem_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_beat: got v=%b l=%b m=%b e=%0d expected all 0",
                     out_valid, last, lane_mask, elem_idx);
        end
        n_checks++;
        if (obs_ctrl !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected 0000", obs_ctrl);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        offer(4'd4, 8'd8);
        n_checks++;
        if ({out_valid, elem_idx, lane_mask, last} !== {1'b1, 8'd0, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL add_beat0: got v=%b e=%0d m=%b l=%b expected v=1 e=0 m=1111 l=0",
                     out_valid, elem_idx, lane_mask, last);
        end
        n_checks++;
        if ({aluControl, regWrite} !== 4'b0001) begin
            n_fail++;
            $display("FAIL add_ctrl: got alu=%b rw=%b expected alu=000 rw=1", aluControl, regWrite);
        end
        tick();
        n_checks++;
        if ({out_valid, elem_idx, lane_mask, last} !== {1'b1, 8'd4, 4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL add_beat1: got v=%b e=%0d m=%b l=%b expected v=1 e=4 m=1111 l=1",
                     out_valid, elem_idx, lane_mask, last);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_done: got ready=%b valid=%b expected ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_sub_backpressure();
        out_ready = 1'b0;
        offer(4'd5, 8'd6);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({out_valid, elem_idx, lane_mask, last, aluControl} !==
                {1'b1, 8'd0, 4'b1111, 1'b0, 3'b100}) begin
                n_fail++;
                $display("FAIL sub_hold%0d: got v=%b e=%0d m=%b l=%b alu=%b expected v=1 e=0 m=1111 l=0 alu=100",
                         c, out_valid, elem_idx, lane_mask, last, aluControl);
            end
            if (c < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, elem_idx, lane_mask, last, aluControl} !==
            {1'b1, 8'd4, 4'b0011, 1'b1, 3'b100}) begin
            n_fail++;
            $display("FAIL sub_beat1: got v=%b e=%0d m=%b l=%b alu=%b expected v=1 e=4 m=0011 l=1 alu=100",
                     out_valid, elem_idx, lane_mask, last, aluControl);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL sub_done: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_latency();
        out_ready = 1'b1;
        offer(4'd1, 8'd4);
        for (int c = 1; c < DC; c++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL div_wait_c%0d: got out_valid=%b expected 0", c, out_valid);
            end
            tick();
        end
        n_checks++;
        if ({out_valid, aluControl, last, lane_mask} !== {1'b1, 3'b010, 1'b1, 4'b1111}) begin
            n_fail++;
            $display("FAIL div_beat: got v=%b alu=%b l=%b m=%b expected v=1 alu=010 l=1 m=1111",
                     out_valid, aluControl, last, lane_mask);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL div_done: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_beq_illegal();
        out_ready = 1'b1;
        offer(4'd9, 8'd20);
        n_checks++;
        if ({out_valid, lane_mask, last, PCSrc, aluControl} !== {1'b1, 4'b0001, 1'b1, 1'b1, 3'b011}) begin
            n_fail++;
            $display("FAIL beq_beat: got v=%b m=%b l=%b pc=%b alu=%b expected v=1 m=0001 l=1 pc=1 alu=011",
                     out_valid, lane_mask, last, PCSrc, aluControl);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL beq_single: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        offer(4'd15, 8'd9);
        n_checks++;
        if ({out_valid, obs_ctrl, lane_mask, last} !== {1'b1, 16'b0000_0100_0000_0001, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_beat: got v=%b ctrl=%b m=%b l=%b expected v=1 ctrl=0000010000000001 m=0001 l=1",
                     out_valid, obs_ctrl, lane_mask, last);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        offer(4'd3, 8'd12);
        n_checks++;
        if ({out_valid, elem_idx, memWrite} !== {1'b1, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL store_beat0: got v=%b e=%0d mw=%b expected v=1 e=0 mw=1", out_valid, elem_idx, memWrite);
        end
        tick();
        n_checks++;
        if ({out_valid, elem_idx} !== {1'b1, 8'd4}) begin
            n_fail++;
            $display("FAIL store_beat1: got v=%b e=%0d expected v=1 e=4", out_valid, elem_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, obs_ctrl, elem_idx, lane_mask, last} !== {1'b1, 30'd0}) begin
            n_fail++;
            $display("FAIL midreset_clear: got ready=%b v=%b ctrl=%h e=%0d m=%b l=%b expected ready=1 rest 0",
                     in_ready, out_valid, obs_ctrl, elem_idx, lane_mask, last);
        end
        offer(4'd2, 8'd3);
        n_checks++;
        if ({out_valid, memToReg, regWrite, elem_idx, lane_mask, last} !==
            {1'b1, 1'b0, 1'b1, 8'd0, 4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL load_after_reset: got v=%b mr=%b rw=%b e=%0d m=%b l=%b expected v=1 mr=0 rw=1 e=0 m=0111 l=1",
                     out_valid, memToReg, regWrite, elem_idx, lane_mask, last);
        end
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_done: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0]    op;
            logic [VW-1:0] vl;
            logic [30:0]   exp_beat;
            int nb;
            int gap;
            int hold;
            bit rdy;
            bit accepted;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: vl = '0;
                1: vl = '1;
                default: vl = VW'($urandom_range(1, 40));
            endcase
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_idle_ready: got %b expected 1", n, in_ready);
            end
            out_ready = 1'($urandom_range(0, 1));
            offer(op, vl);
            nb = exp_beats(op, vl);
            for (int b = 0; b < nb; b++) begin
                gap = 0;
                while (out_valid !== 1'b1 && gap < 64) begin
                    in_valid = 1'($urandom_range(0, 1));
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand%0d_busy_ready: got %b expected 0", n, in_ready);
                    end
                    tick();
                    gap++;
                end
                in_valid = 1'b0;
                n_checks++;
                if (gap != exp_gap(op)) begin
                    n_fail++;
                    $display("FAIL rand%0d_gap b%0d op=%0d: got %0d cycles expected %0d", n, b, op, gap, exp_gap(op));
                end
                if (gap >= 64) break;
                exp_beat = {1'b1, VW'(b * NL), exp_mask(op, vl, b), 1'(b == nb - 1), exp_ctrl(op)};
                accepted = 1'b0;
                hold = 0;
                while (!accepted && hold < 64) begin
                    rdy = ($urandom_range(0, 3) != 0);
                    out_ready = rdy;
                    in_valid = 1'($urandom_range(0, 1));
                    n_checks++;
                    if ({out_valid, elem_idx, lane_mask, last, obs_ctrl} !== exp_beat) begin
                        n_fail++;
                        $display("FAIL rand%0d_beat b%0d op=%0d vlen=%0d: got %h expected %h",
                                 n, b, op, vl, {out_valid, elem_idx, lane_mask, last, obs_ctrl}, exp_beat);
                    end
                    tick();
                    accepted = rdy;
                    hold++;
                end
                in_valid = 1'b0;
            end
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL rand%0d_done op=%0d vlen=%0d: got ready=%b valid=%b expected ready=1 valid=0",
                         n, op, vl, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_backpressure();
        test_div_latency();
        test_beq_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_control_seq.md
# vector_control_seq

Sequenced, parametrised successor to the processor's combinational opcode decoder. It accepts one 4-bit opcode plus a vector length through a valid/ready handshake, registers the decoded datapath controls, and issues them as a stream of per-lane-group beats to the execute stage. It adds three things the old decoder lacked: sub/sub-immediate decode, multi-cycle divide pacing, and backpressure. It sits between fetch/issue and the vector datapath.

## Interface
- NUM_LANES, 4, elements processed per beat (power of 2, ≥1)
- VLEN_W, 8, width of vector length and element index
- DIV_CYCLES, 4, cycles per divide beat (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept; `(state==IDLE) & !rst`
- opcode  in  4  instruction opcode
- vlen  in  VLEN_W  element count; 0 treated as 1
- out_valid  out  1  control beat valid
- out_ready  in  1  execute stage accepts beat
- regWrite, aluSrc, PCSrc, immSrc, flagUpdate, memToReg, memWrite, ra2Src, ra1Src, aluSrc1, aluSrc2, zeroToAlu  out  1 each  registered datapath controls
- aluControl  out  3  000 add, 001 mul, 010 div, 011 compare, 100 sub
- elem_idx  out  VLEN_W  first element index of current beat
- lane_mask  out  NUM_LANES  active lanes in current beat, bit i = lane i
- last  out  1  current beat is final beat
- illegal  out  1  opcode unrecognised

## Operation
- Decode. Each opcode lists the outputs it asserts. Every unlisted output is 0. aluControl is 000 unless stated.
  - 0000 mul: aluControl=001; regWrite, flagUpdate, memToReg.
  - 0001 div: aluControl=010; regWrite, flagUpdate, memToReg.
  - 0010 load: regWrite, aluSrc, flagUpdate, immSrc, aluSrc1, zeroToAlu.
  - 0011 store: aluSrc, immSrc, memWrite, ra2Src, aluSrc1, zeroToAlu.
  - 0100 add: regWrite, flagUpdate, memToReg.
  - 0101 sub: same as add, with aluControl=100.
  - 0110 addi: regWrite, aluSrc, flagUpdate, memToReg, aluSrc1, zeroToAlu.
  - 0111 subi: same as addi, with aluControl=100.
  - 1000 branch: aluSrc, PCSrc, flagUpdate, memToReg, ra2Src, ra1Src, aluSrc1, zeroToAlu.
  - 1001 beq: aluControl=011; PCSrc, flagUpdate, memToReg.
  - Any other opcode: memToReg and illegal only.
- Beat count:
  - Branch, beq and illegal opcodes: always 1 beat, with lane_mask = 1.
  - All other opcodes: beats = ceil(max(vlen,1)/NUM_LANES).
- Per-beat outputs:
  - elem_idx = beat_number × NUM_LANES, truncated to VLEN_W.
  - lane_mask is all-ones except on the final beat, where it covers the remaining `vlen − elem_idx` lanes.
- FSM:
  - IDLE: on in_valid & in_ready, latch the decoded controls, vlen and beat counter. Go to WAIT if the opcode is div and DIV_CYCLES>1; otherwise go to ISSUE.
  - WAIT: out_valid=0. Wait counter is loaded with DIV_CYCLES−2 and counts down; at 0, go to ISSUE.
  - ISSUE: out_valid=1. On out_ready:
    - If last=1, go to IDLE.
    - Otherwise advance elem_idx, then go to WAIT for div, or stay in ISSUE for other opcodes.
- Controls and elem_idx/lane_mask/last hold stable while out_valid & !out_ready.

## Timing
- Reset:
  - Every output registers to 0: controls, aluControl, elem_idx, lane_mask, last, illegal, out_valid.
  - in_ready is 0 during rst and 1 in the first cycle after rst deasserts.
- Non-div latency: accept at cycle N gives out_valid at N+1. With out_ready held high, one beat issues per cycle.
- Div latency: accept at N gives the first beat at N+DIV_CYCLES. Each later beat appears DIV_CYCLES cycles after the previous beat is accepted.
- After the last beat is accepted, in_ready rises the next cycle. Back-to-back instructions therefore have a 1-cycle bubble.
- in_valid while in_ready=0 is ignored. The opcode is not latched.
- rst asserted mid-sequence (WAIT or ISSUE): the next cycle returns to IDLE with all outputs 0. The pending beats are discarded.
- vlen not a multiple of NUM_LANES: the final lane_mask is partial, e.g. vlen=6, NUM_LANES=4 gives 1111 then 0011.
- vlen=2^VLEN_W−1 must not overflow. The beat counter is VLEN_W bits wide.

## Test plan
- Reset, then add (0100) with vlen=8 and out_ready=1 → out_valid at cycle 1 and 2:
  - elem_idx 0, 4; lane_mask 1111, 1111; last on 2nd beat; aluControl=000; regWrite=1; in_ready back at cycle 3.
- Sub (0101) with vlen=6 and out_ready low for 3 cycles → beat 0 is held stable for 3 cycles, then the beats are 1111, then 0011 with last=1 and aluControl=100.
- Div (0001), vlen=4, DIV_CYCLES=4, accepted at cycle 0 → out_valid first high at cycle 4 with aluControl=010; single beat with last=1.
- Beq (1001) with vlen=20 → exactly 1 beat with lane_mask=0001 and PCSrc=1; opcode 1111 → illegal=1, memToReg=1, all other controls 0.
- Store (0011) with vlen=12 and rst pulsed during the 2nd beat → the cycle after rst has out_valid=0, all outputs 0 and in_ready=1; a new load (0010) is then accepted normally with memToReg=0.
